pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) replacing fixed per-stage registers.
//  Carries PC, packed operand data, control word and instruction. Adds valid/ready handshake, hazard stall, flush-to-bubble,
//  reset, and a bubble counter. Control is zeroed on bubble so downstream never writes regs/mem.
// PARAMETERS
//  PC_W     32  program counter width
//  DATA_W   256 packed payload width (e.g. rs1,rs2,rd,imm at 64b each)
//  CTRL_W   8   control word width (pipe_pkg::ctrl_t: MemtoReg,regwrite,branch,MemRead,MemWrite,alu_src,alu_op[1:0])
//  INSTR_W  32  instruction width
//  CNT_W    16  bubble counter width
// PORTS
//  clk        in  1        clock, rising edge
//  rst_n      in  1        asynchronous active-low reset
//  in_valid   in  1        upstream beat valid
//  in_ready   out 1        stage can accept beat
//  in_pc      in  PC_W     upstream PC
//  in_data    in  DATA_W   upstream payload
//  in_ctrl    in  CTRL_W   upstream control word
//  in_instr   in  INSTR_W  upstream instruction
//  stall      in  1        hazard unit freeze: no new beat accepted
//  flush      in  1        branch/exception kill: stage contents become bubble
//  out_valid  out 1        registered beat valid
//  out_ready  in  1        downstream accepts beat
//  out_pc     out PC_W     registered PC
//  out_data   out DATA_W   registered payload
//  out_ctrl   out CTRL_W   registered control; all-zero whenever out_valid=0
//  out_instr  out INSTR_W  registered instruction
//  bubble_cnt out CNT_W    saturating count of bubble cycles
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_ctrl=0, out_pc=0, out_data=0, out_instr=0, bubble_cnt=0; skid entry empty.
//  - Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready at posedge.
//  - Latency: 1 cycle in->out. Full throughput (1 beat/cycle) when out_ready=1 and stall=0.
//  - Hold: out_valid && !out_ready -> all out_* stable (no change until transfer out).
//  - Drain: transfer out with no transfer in -> out_valid<=0, out_ctrl<=0; pc/data/instr keep last value.
//  - Stall: forces in_ready=0; output side still drains normally (so stage emits bubble during load-use stall).
//  - Flush: priority over everything except reset. Next edge: out_valid<=0, out_ctrl<=0, skid entry cleared,
//    any beat presented that cycle discarded (in_ready may be 1; beat is dropped, not stored).
//  - Flush && stall same cycle: flush result; stall only affects in_ready.
//  - bubble_cnt: +1 each cycle out_ready=1 && out_valid=0; saturates at 2^CNT_W-1, never wraps.
//  - Payload fields pass unmodified; no arithmetic on data.
// CONFIGURATION
//  PIPE_SKID_EN defined: 1-entry skid buffer; in_ready is registered = !skid_full && !stall (no comb path
//    out_ready->in_ready). Beat arriving while output held goes to skid; on transfer out, skid moves to output
//    next edge before any new in beat. Order preserved; max 2 beats resident.
//  PIPE_SKID_EN undefined: in_ready = !stall && (!out_valid || out_ready) (combinational); max 1 beat resident.
// STRUCTURE
//  - pipe_pkg: ctrl_t packed struct, CTRL_W, CTRL_NOP='0, default widths.
//  - Sub-module pipe_skid_buf (1-entry holding reg + full flag), instantiated only under PIPE_SKID_EN.
//  - Same module instantiated per stage with different DATA_W/CTRL_W.
// TESTING
//  1 Reset mid-stream: out_valid=1, out_ctrl=8'hA5, drop rst_n -> same cycle out_valid=0, out_ctrl=0, bubble_cnt=0.
//  2 Streaming: out_ready=1, 8 beats pc=0x00,0x04..0x1C back-to-back -> out_pc same seq, 1-cycle delay, no gaps.
//  3 Backpressure: out_ready=0 for 3 cycles with pc=0x40 held -> out_pc=0x40 stable; no-skid: in_ready=0;
//    skid: pc=0x44 accepted then in_ready=0; release -> 0x40 then 0x44, none lost/duplicated.
//  4 Stall: stall=1 2 cycles, out_ready=1 -> in_ready=0, one bubble out_valid=0 out_ctrl=0, bubble_cnt+=2 then resumes.
//  5 Flush with valid in beat pc=0x80, ctrl=8'hFF -> next cycle out_valid=0, out_ctrl=0; 0x80 never appears.
//  6 Saturation: CNT_W=4, out_ready=1, no input 20 cycles -> bubble_cnt=15 and holds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline registers.
package pipe_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int DATA_W_DEF  = 256;
    localparam int CTRL_W      = 8;
    localparam int INSTR_W_DEF = 32;
    localparam int CNT_W_DEF   = 16;

    // Control word carried alongside each instruction.
    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // A bubble carries this control word so nothing downstream writes state.
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry holding register with full flag, used to absorb a beat that
// arrives while the stage output is back-pressured.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic [W-1:0] rd_data
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // Clear wins, a write fills the entry, a read empties it.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr) begin
            full_d = 1'b0;
        end else if (wr_en) begin
            full_d = 1'b1;
            data_d = wr_data;
        end else if (rd_en) begin
            full_d = 1'b0;
        end
    end

    // Entry state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full    = full_q;
    assign rd_data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// hazard stall, flush-to-bubble and a saturating bubble counter.
// Optional macro PIPE_SKID_EN adds a one-entry skid buffer so in_ready has
// no combinational dependence on out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PC_W    = pipe_pkg::PC_W_DEF,
    parameter int DATA_W  = pipe_pkg::DATA_W_DEF,
    parameter int CTRL_W  = pipe_pkg::CTRL_W,
    parameter int INSTR_W = pipe_pkg::INSTR_W_DEF,
    parameter int CNT_W   = pipe_pkg::CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int BEAT_W = PC_W + DATA_W + CTRL_W + INSTR_W;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP);

    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               xfer_in;
    logic               out_free;
    logic               skid_full;
    logic [BEAT_W-1:0]  skid_word;
    logic [PC_W-1:0]    skid_pc;
    logic [DATA_W-1:0]  skid_data;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [INSTR_W-1:0] skid_instr;

    // Output register can take a new beat when empty or being consumed.
    assign out_free = !valid_q || out_ready;
    assign xfer_in  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
    logic skid_wr;
    logic skid_rd;

    // Ready depends only on the registered skid flag and the stall input.
    assign in_ready = !skid_full && !stall;
    assign skid_wr  = xfer_in && !out_free && !flush;
    assign skid_rd  = skid_full && out_free && !flush;

    pipe_skid_buf #(
        .W(BEAT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (skid_wr),
        .rd_en   (skid_rd),
        .wr_data ({in_pc, in_data, in_ctrl, in_instr}),
        .full    (skid_full),
        .rd_data (skid_word)
    );
`else
    // Without a skid entry, accept only when the output slot frees this cycle.
    assign in_ready  = !stall && out_free;
    assign skid_full = 1'b0;
    assign skid_word = '0;
`endif

    assign {skid_pc, skid_data, skid_ctrl, skid_instr} = skid_word;

    // Next output beat: flush kills, held output stays, skid drains before new input.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (out_free) begin
            if (skid_full) begin
                valid_d = 1'b1;
                pc_d    = skid_pc;
                data_d  = skid_data;
                ctrl_d  = skid_ctrl;
                instr_d = skid_instr;
            end else if (xfer_in) begin
                valid_d = 1'b1;
                pc_d    = in_pc;
                data_d  = in_data;
                ctrl_d  = in_ctrl;
                instr_d = in_instr;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
            end
        end
        if (out_ready && !valid_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage register and bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_pc     = pc_q;
    assign out_data   = data_q;
    assign out_ctrl   = ctrl_q;
    assign out_instr  = instr_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: table-driven vectors plus hand-written
// reset, backpressure and counter-saturation sequences.
module tb_pipe_stage_reg;

    localparam logic [31:0] IMASK = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_pc = '0;
    logic [255:0] in_data;
    logic [7:0]   in_ctrl = '0;
    logic [31:0]  in_instr;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_pc;
    logic [255:0] out_data;
    logic [7:0]   out_ctrl;
    logic [31:0]  out_instr;
    logic [15:0]  bubble_cnt;

    logic         s_in_ready;
    logic         s_out_valid;
    logic         s_out_ready = 1'b0;
    logic [31:0]  s_out_pc;
    logic [255:0] s_out_data;
    logic [7:0]   s_out_ctrl;
    logic [31:0]  s_out_instr;
    logic [3:0]   s_bubble_cnt;

    int checks = 0;
    int failures = 0;

    assign in_data  = {8{in_pc}};
    assign in_instr = in_pc ^ IMASK;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl), .in_instr(in_instr),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_ctrl(out_ctrl), .out_instr(out_instr),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(1'b0), .in_ready(s_in_ready),
        .in_pc(32'h0), .in_data(256'h0), .in_ctrl(8'h0), .in_instr(32'h0),
        .stall(1'b0), .flush(1'b0),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_pc(s_out_pc), .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_instr(s_out_instr),
        .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [7:0]  ctrl;
        logic        stl;
        logic        fls;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic [31:0] e_pc;
        logic [7:0]  e_ctrl;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [7:0] c,
                         input logic st, input logic fl, input logic ordy);
        in_valid  = v;
        in_pc     = pc;
        in_ctrl   = c;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        s_out_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [7:0] c,
                                input logic st, input logic fl, input logic ordy,
                                input logic eir, input logic eov, input logic [31:0] epc,
                                input logic [7:0] ec, input logic [15:0] ecnt);
        vec_t r;
        r.vld = v; r.pc = pc; r.ctrl = c; r.stl = st; r.fls = fl; r.ordy = ordy;
        r.e_irdy = eir; r.e_ovld = eov; r.e_pc = epc; r.e_ctrl = ec; r.e_cnt = ecnt;
        return r;
    endfunction

    initial begin
        // Streaming, stall, flush, flush+stall and drain vectors.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1, 32'(4 * i), 8'(8'h10 + i), 0, 0, 1, 1, 1, 32'(4 * i), 8'(8'h10 + i), 16'd1));
        end
        tbl.push_back(mk(1, 32'h20, 8'h20, 1, 0, 1, 0, 0, 32'h1C, 8'h00, 16'd1));
        tbl.push_back(mk(1, 32'h20, 8'h20, 1, 0, 1, 0, 0, 32'h1C, 8'h00, 16'd2));
        tbl.push_back(mk(1, 32'h20, 8'h20, 0, 0, 1, 1, 1, 32'h20, 8'h20, 16'd3));
        tbl.push_back(mk(1, 32'h80, 8'hFF, 0, 1, 1, 1, 0, 32'h20, 8'h00, 16'd3));
        tbl.push_back(mk(0, 32'h80, 8'hFF, 0, 0, 1, 1, 0, 32'h20, 8'h00, 16'd4));
        tbl.push_back(mk(1, 32'h24, 8'h33, 0, 0, 1, 1, 1, 32'h24, 8'h33, 16'd5));
        tbl.push_back(mk(1, 32'h88, 8'h77, 1, 1, 0, 0, 0, 32'h24, 8'h00, 16'd5));
        tbl.push_back(mk(0, 32'h88, 8'h77, 0, 0, 0, 1, 0, 32'h24, 8'h00, 16'd5));
        tbl.push_back(mk(1, 32'h28, 8'h44, 0, 0, 0, 1, 1, 32'h28, 8'h44, 16'd5));
        tbl.push_back(mk(0, 32'h28, 8'h44, 0, 0, 1, 1, 0, 32'h28, 8'h00, 16'd5));

        // Reset mid-stream.
        do_reset();
        chk("reset_valid", out_valid, 0);
        chk("reset_cnt", bubble_cnt, 0);
        drive(0, 32'h0, 8'h0, 0, 0, 1);
        cyc();
        cyc();
        chk("pre_reset_cnt", bubble_cnt, 2);
        drive(1, 32'h10, 8'hA5, 0, 0, 0);
        cyc();
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_ctrl", out_ctrl, 8'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_ctrl", out_ctrl, 0);
        chk("async_reset_cnt", bubble_cnt, 0);
        chk("async_reset_pc", out_pc, 0);
        chk("async_reset_data", out_data, 0);
        do_reset();

        // Table-driven vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].vld, tbl[i].pc, tbl[i].ctrl, tbl[i].stl, tbl[i].fls, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_irdy);
            cyc();
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ovld);
            chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_out_ctrl", i), out_ctrl, tbl[i].e_ctrl);
            chk($sformatf("vec%0d_out_data", i), out_data, {8{tbl[i].e_pc}});
            chk($sformatf("vec%0d_out_instr", i), out_instr, tbl[i].e_pc ^ IMASK);
            chk($sformatf("vec%0d_bubble_cnt", i), bubble_cnt, tbl[i].e_cnt);
        end

        // Backpressure with output held for three cycles.
        do_reset();
        drive(1, 32'h40, 8'h11, 0, 0, 0);
        #1;
        chk("bp_first_ready", in_ready, 1);
        cyc();
        chk("bp_first_pc", out_pc, 32'h40);
        for (int k = 0; k < 3; k++) begin
`ifdef PIPE_SKID_EN
            if (k == 0) drive(1, 32'h44, 8'h12, 0, 0, 0);
            else        drive(1, 32'h48, 8'h13, 0, 0, 0);
            #1;
            chk($sformatf("bp_hold%0d_ready", k), in_ready, (k == 0) ? 1'b1 : 1'b0);
`else
            drive(1, 32'h44, 8'h12, 0, 0, 0);
            #1;
            chk($sformatf("bp_hold%0d_ready", k), in_ready, 0);
`endif
            cyc();
            chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
            chk($sformatf("bp_hold%0d_pc", k), out_pc, 32'h40);
            chk($sformatf("bp_hold%0d_ctrl", k), out_ctrl, 8'h11);
        end
`ifdef PIPE_SKID_EN
        drive(1, 32'h48, 8'h13, 0, 0, 1);
        #1;
        chk("bp_rel_ready", in_ready, 0);
        cyc();
        chk("bp_rel_pc", out_pc, 32'h44);
        chk("bp_rel_ctrl", out_ctrl, 8'h12);
        #1;
        chk("bp_next_ready", in_ready, 1);
        cyc();
        chk("bp_next_pc", out_pc, 32'h48);
        chk("bp_next_ctrl", out_ctrl, 8'h13);
`else
        drive(1, 32'h44, 8'h12, 0, 0, 1);
        #1;
        chk("bp_rel_ready", in_ready, 1);
        cyc();
        chk("bp_rel_pc", out_pc, 32'h44);
        chk("bp_rel_ctrl", out_ctrl, 8'h12);
`endif
        drive(0, 32'h0, 8'h0, 0, 0, 1);
        cyc();
        chk("bp_drain_valid", out_valid, 0);
        chk("bp_drain_ctrl", out_ctrl, 0);

        // Bubble counter saturation on the 4-bit instance.
        do_reset();
        s_out_ready = 1'b1;
        for (int k = 0; k < 14; k++) cyc();
        chk("sat_cnt14", s_bubble_cnt, 14);
        for (int k = 0; k < 6; k++) cyc();
        chk("sat_cnt20", s_bubble_cnt, 15);
        for (int k = 0; k < 3; k++) cyc();
        chk("sat_hold", s_bubble_cnt, 15);
        chk("sat_valid", s_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
